reg_bank_p: RTL and testbench
=============================

REG_BANK_P -- requirements
Module: reg_bank_p

Interface
REQ-001 Parameter DW, default 16, data width of every register and data port.
REQ-002 Parameter NREG, default 35, number of registers, indices 0..NREG-1.
REQ-003 Parameter SW, default 6, select-field width; NREG SHALL be at most 2**SW - 1.
REQ-004 Parameter WR, default NREG-1, index of the working register used for memory transfers.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports SHALL be, in order:
- clk  in  1  clock.
- rst  in  1  sync active-high reset.
- mc  in  2  bit0 memory write, bit1 memory read.
- sel_a  in  SW  operand A register index.
- sel_b  in  SW  operand B register index.
- sel_c  in  SW  write-back register index.
- data_c  in  DW  write-back data.
- mem_rdata  in  DW  memory read data.
- mem_ack  in  1  memory completion strobe.
- a  out  DW  operand A.
- b  out  DW  operand B.
- wr_data  out  DW  memory write data.
- mem_req  out  1  memory request.
- mem_we  out  1  request is a write.
- busy  out  1  memory transfer in progress.
REQ-007 Any select value >= NREG SHALL be a "no register" sentinel.

Function
REQ-008 The FSM SHALL have states IDLE, MWR and MRD, and reset into IDLE.
REQ-009 In IDLE with mc[0]=1, the next edge SHALL latch wr_data <= reg[WR] and go to MWR; mc[0] takes priority over mc[1].
REQ-010 In IDLE with mc=2'b10, the next edge SHALL go to MRD.
REQ-011 mem_req SHALL be 1 exactly in MWR/MRD, mem_we SHALL be 1 exactly in MWR, and busy SHALL equal mem_req; all three are registered outputs.
REQ-012 In MWR, mem_ack=1 SHALL return the FSM to IDLE at that edge; wr_data SHALL hold its value until the next MWR entry.
REQ-013 In MRD, mem_ack=1 SHALL write reg[WR] <= mem_rdata and return the FSM to IDLE at that edge.
REQ-014 mem_ack seen in IDLE SHALL be ignored.
REQ-015 The request SHALL wait indefinitely for mem_ack; there is no timeout.
REQ-016 In IDLE with mc=0 and sel_c < NREG, the edge SHALL write reg[sel_c] <= data_c; a sentinel sel_c writes nothing.
REQ-017 While busy=1, mc and write port C SHALL be ignored; reads continue.
REQ-018 Reads SHALL be registered with 1-cycle latency: each edge loads a <= reg[sel_a] when sel_a < NREG, otherwise a holds its value.
REQ-019 Operand b SHALL follow the same rule as a, using sel_b.
REQ-020 Write-through bypass: if a register is written at the same edge it is read, a/b SHALL receive the new value (data_c or mem_rdata), not the old one.
REQ-021 sel_a == sel_b SHALL be legal, and both outputs SHALL receive the same value.
REQ-022 A sel_c write to WR in IDLE SHALL be allowed and SHALL be visible to a subsequent MWR latch.

Reset
REQ-023 rst=1 SHALL, at the edge, clear all registers, a, b and wr_data to 0, set mem_req, mem_we and busy to 0, and force IDLE.
REQ-024 Reset SHALL take priority over every other action, including a mem_ack arriving in the same cycle.
REQ-025 Reset mid-transfer SHALL abort the transfer with no register update; mem_req SHALL be 0 from the following cycle.
REQ-026 There SHALL be no initial-block register preloading; registers are loaded only by write port C or MRD.

Verification
REQ-027 Write/read: write reg[3]=16'h00F0 via port C, then sel_a=3 -> a=16'h00F0 one cycle later; sel_b=40 (sentinel) -> b holds 0.
REQ-028 Bypass: sel_c=5 with data_c=16'hBEEF and sel_a=5 in the same cycle -> a=16'hBEEF at that edge.
REQ-029 Memory write: reg[34]=16'h000F, pulse mc=2'b01, hold mem_ack=0 for 3 cycles, then assert it -> wr_data=16'h000F, mem_req=mem_we=busy=1 for 4 cycles, then 0.
REQ-030 Memory read: mc=2'b10, mem_ack after 2 cycles with mem_rdata=16'h1234, sel_a=34 -> reg[34]=16'h1234, a=16'h1234 at the ack edge (bypass).
REQ-031 Busy lockout: during MRD, sel_c=1 with data_c=16'hFFFF and mc=2'b01 -> reg[1] unchanged, no MWR after return to IDLE.
REQ-032 Reset abort: rst=1 in the same cycle as mem_ack in MRD -> reg[34]=0, IDLE, mem_req=0; a subsequent mc=2'b11 -> MWR is selected.

Source files
------------

// File: rtl/reg_bank_p.sv
// reg_bank_p: register bank with two registered read ports (a, b), one
// write-back port (c) and a small memory-transfer engine that moves the
// working register WR to/from an external memory.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   mc             bit0 = memory write (priority), bit1 = memory read
//   sel_a, sel_b   read indices; values >= NREG mean "no register" (hold)
//   sel_c, data_c  write-back index/data; sentinel index writes nothing
//   mem_rdata      read data from memory, taken on mem_ack in MRD
//   mem_ack        memory completion strobe
//   a, b           registered read data (1-cycle latency, write-through)
//   wr_data        value of reg[WR] captured when a memory write starts
//   mem_req        transfer in progress (MWR or MRD)
//   mem_we         transfer is a write
//   busy           same as mem_req
module reg_bank_p #(
  parameter int DW   = 16,
  parameter int NREG = 35,
  parameter int SW   = 6,
  parameter int WR   = NREG - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mc,
  input  logic [SW-1:0] sel_a,
  input  logic [SW-1:0] sel_b,
  input  logic [SW-1:0] sel_c,
  input  logic [DW-1:0] data_c,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [DW-1:0] wr_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, MWR, MRD} state_t;

  localparam logic [SW-1:0] NSEL = SW'(NREG);
  localparam logic [SW-1:0] WSEL = SW'(WR);

  state_t        state;
  logic [DW-1:0] regs [NREG];

  // Single register write per edge: either port C (idle, no transfer
  // request) or the memory-read completion into WR.
  logic          wen;
  logic [SW-1:0] widx;
  logic [DW-1:0] wdata;

  always_comb begin
    wen   = 1'b0;
    widx  = sel_c;
    wdata = data_c;
    case (state)
      IDLE: wen = (mc == 2'b00) && (sel_c < NSEL);
      MRD: begin
        wen   = mem_ack;
        widx  = WSEL;
        wdata = mem_rdata;
      end
      default: wen = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      a       <= '0;
      b       <= '0;
      wr_data <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wen) regs[widx] <= wdata;

      // Write-through: a read of the register being written sees new data.
      if (sel_a < NSEL) a <= (wen && widx == sel_a) ? wdata : regs[sel_a];
      if (sel_b < NSEL) b <= (wen && widx == sel_b) ? wdata : regs[sel_b];

      case (state)
        IDLE: begin
          if (mc[0]) begin
            wr_data <= regs[WSEL];
            state   <= MWR;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
            busy    <= 1'b1;
          end else if (mc[1]) begin
            state   <= MRD;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            busy    <= 1'b1;
          end
        end
        MWR, MRD: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_p.sv
// Testbench for reg_bank_p: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural
// model of the register bank and transfer engine.
module tb_reg_bank_p;
  localparam int DW = 16, NREG = 35, SW = 6, WR = NREG - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mc = 2'b00;
  logic [SW-1:0] sel_a = 6'd63, sel_b = 6'd63, sel_c = 6'd63;
  logic [DW-1:0] data_c = '0, mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] a, b, wr_data;
  logic          mem_req, mem_we, busy;

  reg_bank_p #(.DW(DW), .NREG(NREG), .SW(SW), .WR(WR)) dut (
    .clk(clk), .rst(rst), .mc(mc), .sel_a(sel_a), .sel_b(sel_b),
    .sel_c(sel_c), .data_c(data_c), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .a(a), .b(b), .wr_data(wr_data), .mem_req(mem_req), .mem_we(mem_we),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_xfer: 0 = no transfer pending, 1 = memory write pending, 2 = memory read pending
  logic [DW-1:0] m_reg [NREG];
  logic [DW-1:0] m_a, m_b, m_wrd;
  int            m_xfer;

  always @(posedge clk) begin
    int  idx;
    bit  do_wr;
    logic [DW-1:0] val;
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_a = '0; m_b = '0; m_wrd = '0; m_xfer = 0;
    end else begin
      do_wr = 0; idx = 0; val = '0;
      if (m_xfer == 0) begin
        if (mc[0]) begin m_wrd = m_reg[WR]; m_xfer = 1; end
        else if (mc[1]) m_xfer = 2;
        else if (int'(sel_c) < NREG) begin do_wr = 1; idx = int'(sel_c); val = data_c; end
      end else if (mem_ack) begin
        if (m_xfer == 2) begin do_wr = 1; idx = WR; val = mem_rdata; end
        m_xfer = 0;
      end
      if (do_wr) m_reg[idx] = val;
      // reading after the write gives write-through for free
      if (int'(sel_a) < NREG) m_a = m_reg[sel_a];
      if (int'(sel_b) < NREG) m_b = m_reg[sel_b];
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("a", 32'(a), 32'(m_a));
      chk("b", 32'(b), 32'(m_b));
      chk("wr_data", 32'(wr_data), 32'(m_wrd));
      chk("mem_req", 32'(mem_req), 32'(m_xfer != 0));
      chk("mem_we", 32'(mem_we), 32'(m_xfer == 1));
      chk("busy", 32'(busy), 32'(m_xfer != 0));
    end
  end

  // advance one edge; inputs change only on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int hi;
    @(negedge clk);
    step();                       // reset edge
    check_en = 1'b1;
    chk("rst_a", 32'(a), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    rst = 1'b0;

    // write/read, sentinel read holds
    sel_c = 6'd3; data_c = 16'h00F0; step();
    sel_c = 6'd63; sel_a = 6'd3; sel_b = 6'd40; step();
    chk("wr_rd_a", 32'(a), 32'h00F0);
    chk("sentinel_b", 32'(b), 32'h0);

    // bypass
    sel_c = 6'd5; data_c = 16'hBEEF; sel_a = 6'd5; step();
    chk("bypass_a", 32'(a), 32'hBEEF);

    // memory write with delayed ack
    sel_c = 6'd34; data_c = 16'h000F; step();
    sel_c = 6'd63; mc = 2'b01; step();
    mc = 2'b00;
    chk("mwr_wrdata", 32'(wr_data), 32'h000F);
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req && mem_we && busy) hi++;
      mem_ack = (i == 3); step();
    end
    mem_ack = 1'b0;
    chk("mwr_cycles", 32'(hi), 32'd4);
    chk("mwr_done", 32'(mem_req), 32'h0);

    // memory read with bypass onto a
    mc = 2'b10; step();
    mc = 2'b00; step(); step();
    mem_ack = 1'b1; mem_rdata = 16'h1234; sel_a = 6'd34; step();
    mem_ack = 1'b0;
    chk("mrd_bypass_a", 32'(a), 32'h1234);
    chk("mrd_done", 32'(mem_req), 32'h0);

    // busy lockout
    mc = 2'b10; step();
    mc = 2'b01; sel_c = 6'd1; data_c = 16'hFFFF; sel_a = 6'd63; step(); step();
    mc = 2'b00; sel_c = 6'd63; mem_ack = 1'b1; mem_rdata = 16'h5555; step();
    mem_ack = 1'b0; step();
    chk("lockout_no_mwr", 32'(mem_req), 32'h0);
    sel_a = 6'd1; step();
    chk("lockout_reg1", 32'(a), 32'h0);

    // reset wins over ack, then mc=11 selects memory write
    mc = 2'b10; step();
    mc = 2'b00; mem_ack = 1'b1; mem_rdata = 16'hAAAA; rst = 1'b1; step();
    chk("rst_abort_req", 32'(mem_req), 32'h0);
    rst = 1'b0; mem_ack = 1'b0; mc = 2'b11; step();
    mc = 2'b00;
    chk("mc11_we", 32'(mem_we), 32'h1);
    mem_ack = 1'b1; step();
    mem_ack = 1'b0; sel_a = 6'd34; step();
    chk("rst_abort_reg34", 32'(a), 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 9))
        0: mc = 2'b01;
        1: mc = 2'b10;
        2: mc = 2'b11;
        default: mc = 2'b00;
      endcase
      mem_ack   = ($urandom_range(0, 2) == 0);
      sel_a     = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(30, 34));
      sel_b     = ($urandom_range(0, 3) == 0) ? sel_a : 6'($urandom_range(0, 63));
      sel_c     = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(30, 36));
      data_c    = 16'($urandom);
      mem_rdata = 16'($urandom);
      step();
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
